datapath_ctrl: RTL and testbench

Instruction sequencer for the 4-bit accumulator datapath. It accepts opcode/operand/repeat-count instructions over a valid/ready handshake. It drives the datapath's operand bus and its SelB, LoadAC and AddAlu controls for the required number of cycles, then pulses `done` once the accumulator output reflects the final result. It sits between a test/stimulus source (or a higher-level controller) and one `datapath` instance, and is the only driver of that instance's control inputs.

---
 rtl/datapath_ctrl_pkg.sv | 22 ++
 rtl/datapath.sv | 28 ++
 rtl/rep_counter.sv | 28 ++
 rtl/datapath_ctrl.sv | 87 ++++++++
 tb/tb_datapath_ctrl.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/datapath_ctrl_pkg.sv
// Shared constants for the accumulator-datapath instruction sequencer:
// default widths, opcode values and FSM state encoding.
package datapath_ctrl_pkg;

  localparam int W  = 4;
  localparam int CW = 4;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_ADD  = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Every opcode except NOP writes the accumulator on each EXEC cycle.
  function automatic logic op_writes_ac(input logic [1:0] op);
    return op != OP_NOP;
  endfunction

endpackage

// File: rtl/datapath.sv
// 4-bit accumulator datapath: AC loads either ABus or AC+ABus (carry dropped).
module datapath #(
  parameter int W = datapath_ctrl_pkg::W
) (
  input  logic         clock,
  input  logic [W-1:0] ABus,
  input  logic         SelB,
  input  logic         LoadAC,
  input  logic         AddAlu,
  output logic [W-1:0] OutBus
);

  logic [W-1:0] r_ac;
  logic [W-1:0] w_alu;
  logic [W-1:0] w_mux;

  assign w_alu  = AddAlu ? (r_ac + ABus) : r_ac;
  assign w_mux  = SelB ? w_alu : ABus;
  assign OutBus = r_ac;

  // AC has no reset; software clears it with a CLR instruction.
  always_ff @(posedge clock) begin
    if (LoadAC) begin
      r_ac <= w_mux;
    end
  end

endmodule

// File: rtl/rep_counter.sv
// Loadable CW-bit down-counter that saturates at zero and flags it.
module rep_counter #(
  parameter int CW = datapath_ctrl_pkg::CW
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          load,
  input  logic          dec,
  input  logic [CW-1:0] value,
  output logic          zero
);

  logic [CW-1:0] r_count;

  // Holding at zero keeps a maximum count from wrapping into another pass.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= value;
    end else if (dec && (r_count != '0)) begin
      r_count <= r_count - CW'(1);
    end
  end

  assign zero = (r_count == '0);

endmodule

// File: rtl/datapath_ctrl.sv
// Instruction sequencer: accepts op/data/cnt over valid/ready and drives the
// datapath controls for cnt+1 cycles, then pulses done.
module datapath_ctrl #(
  parameter int W  = datapath_ctrl_pkg::W,
  parameter int CW = datapath_ctrl_pkg::CW
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [1:0]    instr_op,
  input  logic [W-1:0]  instr_data,
  input  logic [CW-1:0] instr_cnt,
  input  logic          flush,
  output logic [W-1:0]  a_bus,
  output logic          sel_b,
  output logic          load_ac,
  output logic          add_alu,
  output logic          busy,
  output logic          done
);

  import datapath_ctrl_pkg::*;

  logic [1:0]   r_state;
  logic [1:0]   w_state_next;
  logic [1:0]   r_op;
  logic [W-1:0] r_data;
  logic         r_armed;
  logic         w_accept;
  logic         w_exec;
  logic         w_zero;

  assign w_exec   = (r_state == S_EXEC);
  assign w_accept = instr_valid && instr_ready;

  rep_counter #(.CW(CW)) u_rep_counter (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (w_accept),
    .dec     (w_exec && !flush),
    .value   (instr_cnt),
    .zero    (w_zero)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_next = S_EXEC;
      S_EXEC: begin
        if (flush) begin
          w_state_next = S_IDLE;
        end else if (w_zero) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // r_armed holds off instr_ready until the first clock after reset release.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_op    <= OP_NOP;
      r_data  <= '0;
      r_armed <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_armed <= 1'b1;
      if (w_accept) begin
        r_op   <= instr_op;
        r_data <= instr_data;
      end
    end
  end

  assign instr_ready = (r_state == S_IDLE) && r_armed && !flush;
  assign a_bus       = (w_exec && (r_op != OP_CLR)) ? r_data : '0;
  assign sel_b       = w_exec && (r_op == OP_ADD);
  assign add_alu     = sel_b;
  assign load_ac     = w_exec && op_writes_ac(r_op) && !flush;
  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DONE) && !flush;

endmodule

// File: tb/tb_datapath_ctrl.sv
// Directed bench for datapath_ctrl driving a datapath instance; expected
// values are hand-computed constants per instruction sequence.
module tb_datapath_ctrl;
  import datapath_ctrl_pkg::*;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       instr_valid = 1'b0;
  logic       flush = 1'b0;
  logic [1:0] instr_op = 2'b00;
  logic [3:0] instr_data = 4'd0;
  logic [3:0] instr_cnt = 4'd0;
  logic       instr_ready;
  logic [3:0] a_bus;
  logic       sel_b;
  logic       load_ac;
  logic       add_alu;
  logic       busy;
  logic       done;
  logic [3:0] out_bus;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  datapath_ctrl dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_op    (instr_op),
    .instr_data  (instr_data),
    .instr_cnt   (instr_cnt),
    .flush       (flush),
    .a_bus       (a_bus),
    .sel_b       (sel_b),
    .load_ac     (load_ac),
    .add_alu     (add_alu),
    .busy        (busy),
    .done        (done)
  );

  datapath u_dp (
    .clock  (clock),
    .ABus   (a_bus),
    .SelB   (sel_b),
    .LoadAC (load_ac),
    .AddAlu (add_alu),
    .OutBus (out_bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet_outputs(input string tag);
    chk({tag, "_load_ac"}, 32'(load_ac), 0);
    chk({tag, "_sel_b"}, 32'(sel_b), 0);
    chk({tag, "_add_alu"}, 32'(add_alu), 0);
    chk({tag, "_a_bus"}, 32'(a_bus), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_ready"}, 32'(instr_ready), 0);
  endtask

  // Entered at a negedge of an idle, ready cycle; leaves at the negedge of T+3+cnt.
  task automatic run(input logic [1:0] op, input logic [3:0] data, input logic [3:0] cnt,
                     input logic [3:0] exp_out);
    @(posedge clock); #1;
    instr_op = op; instr_data = data; instr_cnt = cnt; instr_valid = 1'b1;
    @(negedge clock);
    chk("ready_before_accept", 32'(instr_ready), 1);
    @(posedge clock); #1;
    instr_valid = 1'b0;
    for (int i = 0; i <= int'(cnt); i++) begin
      @(negedge clock);
      chk("exec_busy", 32'(busy), 1);
      chk("exec_ready", 32'(instr_ready), 0);
      chk("exec_done", 32'(done), 0);
      chk("exec_load_ac", 32'(load_ac), 32'(op != OP_NOP));
      chk("exec_sel_b", 32'(sel_b), 32'(op == OP_ADD));
      chk("exec_add_alu", 32'(add_alu), 32'(op == OP_ADD));
      if (op != OP_NOP) chk("exec_a_bus", 32'(a_bus), (op == OP_CLR) ? 0 : 32'(data));
      @(posedge clock); #1;
    end
    @(negedge clock);
    chk("done_pulse", 32'(done), 1);
    chk("done_load_ac", 32'(load_ac), 0);
    chk("done_sel_b", 32'(sel_b), 0);
    chk("done_ready", 32'(instr_ready), 0);
    chk("done_out_bus", 32'(out_bus), 32'(exp_out));
    @(posedge clock); #1;
    @(negedge clock);
    chk("idle_ready", 32'(instr_ready), 1);
    chk("idle_done", 32'(done), 0);
    chk("idle_busy", 32'(busy), 0);
    $display("op=%0d data=%0d cnt=%0d out_bus=%0d expected=%0d", op, data, cnt, out_bus, exp_out);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    chk_quiet_outputs("reset");
    reset_n = 1'b1;
    @(negedge clock);
    chk("ready_after_reset", 32'(instr_ready), 1);

    run(OP_CLR, 4'd7, 4'd0, 4'd0);
    run(OP_LOAD, 4'd5, 4'd0, 4'd5);
    run(OP_ADD, 4'd3, 4'd2, 4'd14);
    run(OP_LOAD, 4'd9, 4'd0, 4'd9);
    run(OP_ADD, 4'd9, 4'd0, 4'd2);
    run(OP_NOP, 4'd10, 4'd4, 4'd2);
    run(OP_LOAD, 4'd7, 4'd15, 4'd7);
    run(OP_CLR, 4'd0, 4'd0, 4'd0);

    // Flush in the third EXEC cycle: two adds of 1 committed, no done.
    @(posedge clock); #1;
    instr_op = OP_ADD; instr_data = 4'd1; instr_cnt = 4'd7; instr_valid = 1'b1;
    @(posedge clock); #1;
    instr_valid = 1'b0;
    @(negedge clock);
    chk("flush_t1_load_ac", 32'(load_ac), 1);
    @(posedge clock); #1;
    @(negedge clock);
    chk("flush_t2_load_ac", 32'(load_ac), 1);
    @(posedge clock); #1;
    flush = 1'b1;
    @(negedge clock);
    chk("flush_cycle_load_ac", 32'(load_ac), 0);
    chk("flush_cycle_done", 32'(done), 0);
    @(posedge clock); #1;
    flush = 1'b0;
    @(negedge clock);
    chk("flush_after_busy", 32'(busy), 0);
    chk("flush_after_ready", 32'(instr_ready), 1);
    chk("flush_after_done", 32'(done), 0);
    chk("flush_after_out_bus", 32'(out_bus), 2);
    $display("flush test out_bus=%0d expected=2", out_bus);

    // Flush while idle blocks acceptance of a presented instruction.
    @(posedge clock); #1;
    flush = 1'b1;
    instr_op = OP_LOAD; instr_data = 4'd8; instr_cnt = 4'd0; instr_valid = 1'b1;
    @(negedge clock);
    chk("idle_flush_ready", 32'(instr_ready), 0);
    @(posedge clock); #1;
    flush = 1'b0; instr_valid = 1'b0;
    @(negedge clock);
    chk("idle_flush_not_accepted", 32'(busy), 0);
    chk("idle_flush_out_bus", 32'(out_bus), 2);
    $display("idle flush test busy=%0d expected=0", busy);

    // Reset asserted mid-EXEC, with a new instruction held on the inputs.
    @(posedge clock); #1;
    instr_op = OP_LOAD; instr_data = 4'd4; instr_cnt = 4'd5; instr_valid = 1'b1;
    @(posedge clock); #1;
    instr_data = 4'd6; instr_cnt = 4'd0;
    @(negedge clock);
    chk("rst_exec_a_bus_stable", 32'(a_bus), 4);
    chk("rst_exec_load_ac", 32'(load_ac), 1);
    @(posedge clock); #2;
    reset_n = 1'b0;
    #1;
    chk_quiet_outputs("async_reset");
    @(negedge clock); #1;
    reset_n = 1'b1;
    @(negedge clock);
    chk("rst_release_ready", 32'(instr_ready), 1);
    @(posedge clock); #1;
    instr_valid = 1'b0;
    @(negedge clock);
    chk("held_accept_busy", 32'(busy), 1);
    chk("held_accept_load_ac", 32'(load_ac), 1);
    chk("held_accept_a_bus", 32'(a_bus), 6);
    @(posedge clock); #1;
    @(negedge clock);
    chk("held_accept_done", 32'(done), 1);
    chk("held_accept_out_bus", 32'(out_bus), 6);
    $display("reset test out_bus=%0d expected=6", out_bus);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
